axis_out_arb: RTL and testbench



---
 rtl/axis_out_arb_pkg.sv | 71 +++++++
 rtl/axis_out_arb_skid_buf.sv | 78 +++++++
 rtl/axis_out_arb.sv | 147 ++++++++++++++
 tb/tb_axis_out_arb.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_out_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_out_arb_pkg
//
// Shared definitions for the output-stage arbiter:
//   - ROWS / COLS / WORD_WIDTH_ACC geometry macros (fall back to defaults when
//     the shared params include has not already defined them)
//   - tuser_st sideband carried with every accumulator block
//   - FSM state encodings for axis_out_arb
//   - bits_req()  : width of a source index for a given source count
//   - rr_pick()   : rotate-and-priority-encode used for round-robin selection
//
// Optional feature macro used by the arbiter: OUT_ARB_SKID_EN
// -----------------------------------------------------------------------------
`ifndef ROWS
`define ROWS 2
`endif
`ifndef COLS
`define COLS 2
`endif
`ifndef WORD_WIDTH_ACC
`define WORD_WIDTH_ACC 16
`endif

package axis_out_arb_pkg;

  localparam int ROWS_P           = `ROWS;
  localparam int COLS_P           = `COLS;
  localparam int WORD_WIDTH_ACC_P = `WORD_WIDTH_ACC;

  // Sideband travelling with each accumulator block.
  typedef struct packed {
    logic [3:0] tag;
    logic [3:0] kind;
  } tuser_st;

  localparam int USER_W = $bits(tuser_st);

  // Upper bound on the number of sources rr_pick can search.
  localparam int MAX_REQ = 32;

  // Arbiter FSM encodings.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Width of a source index; never zero so a 1-source build still elaborates.
  function automatic int bits_req(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns the first set bit of req[n-1:0] searching ptr+1, ptr+2, ... mod n.
  // If nothing is set the pointer itself is returned (caller only uses the
  // result when at least one request is pending).
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int n,
                                 input int ptr);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n) begin
        idx = (ptr + i) % n;
        if (!found && req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/axis_out_arb_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
//
// Two-entry skid register. Outputs (m_valid, m_data) come straight from flops,
// and s_ready depends only on the local fill level, so there is no
// combinational path from m_ready to s_ready. Two entries are enough to keep
// 1 beat/cycle while m_ready stalls are absorbed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (empties buffer)
//   s_valid/s_ready     upstream handshake, s_data payload
//   m_valid/m_ready     downstream handshake, m_data payload
// -----------------------------------------------------------------------------
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push;
  logic         pop;

  assign s_ready = (cnt_q != 2'd2);
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = rd_q ? mem1_q : mem0_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    if (push) begin
      if (wr_q) begin
        mem1_d = s_data;
      end else begin
        mem0_d = s_data;
      end
      wr_d = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_out_arb.sv
// -----------------------------------------------------------------------------
// axis_out_arb
//
// Round-robin, packet-locked AXI-Stream arbiter sharing the output shifter
// between N_REQ accumulator sources. A source is granted in IDLE (one
// registered arbitration cycle), then owns the output until its s_last beat
// is accepted; priority then rotates to the source after it.
//
// Handshake semantics (all interfaces): a beat transfers on a rising aclk edge
// where valid and ready are both high. valid never waits for ready; ready may
// depend on valid-independent state only (and, in the passthrough build, on
// m_ready). Data/user/last are meaningful only while valid is high.
//
// Ports:
//   aclk, aresetn    clock, asynchronous active-low reset
//   s_valid[N]       per-source valid         s_ready[N]  per-source ready
//   s_last[N]        per-source end-of-packet s_user[N]   per-source sideband
//   s_data           N packed COLS*ROWS*WORD_WIDTH blocks (source 0 in LSBs)
//   m_ready          shifter ready
//   m_valid, m_last, m_user, m_data   granted source towards the shifter
//   m_grant          index of current / last granted source
//   dbg_state        FSM state (ST_IDLE / ST_LOCK)
//
// Optional feature: OUT_ARB_SKID_EN. When defined, every m_* output comes from
// a 2-entry skid register (1 extra cycle of latency, full throughput, no
// m_ready->s_ready combinational path); the FSM then advances on the handshake
// into the skid register. When undefined, m_* is a combinational passthrough.
// -----------------------------------------------------------------------------
module axis_out_arb
  import axis_out_arb_pkg::*;
#(
  parameter int  N_REQ      = 2,
  parameter int  ROWS       = ROWS_P,
  parameter int  COLS       = COLS_P,
  parameter int  WORD_WIDTH = WORD_WIDTH_ACC_P,
  localparam int BITS_REQ   = bits_req(N_REQ),
  localparam int DATA_W     = COLS * ROWS * WORD_WIDTH
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_REQ-1:0]        s_valid,
  output logic [N_REQ-1:0]        s_ready,
  input  logic [N_REQ-1:0]        s_last,
  input  tuser_st [N_REQ-1:0]     s_user,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic                    m_last,
  output tuser_st                 m_user,
  output logic [DATA_W-1:0]       m_data,
  output logic [BITS_REQ-1:0]     m_grant,
  output logic [0:0]              dbg_state
);

  logic [0:0]          state_q,  state_d;
  logic [BITS_REQ-1:0] grant_q,  grant_d;
  logic [BITS_REQ-1:0] rr_ptr_q, rr_ptr_d;

  // Granted source as seen on the upstream side of the output stage.
  logic              locked;
  logic              up_valid;
  logic              up_ready;
  logic              up_last;
  logic              up_hs;
  tuser_st           up_user;
  logic [DATA_W-1:0] up_data;

  assign locked   = (state_q == ST_LOCK);
  assign up_valid = locked && s_valid[grant_q];
  assign up_last  = s_last[grant_q];
  assign up_user  = s_user[grant_q];
  assign up_data  = s_data[int'(grant_q)*DATA_W +: DATA_W];
  assign up_hs    = up_valid && up_ready;

  assign m_grant   = grant_q;
  assign dbg_state = state_q;

  // Only the granted source ever sees ready; everyone else waits.
  always_comb begin
    s_ready = '0;
    if (locked) begin
      s_ready[grant_q] = up_ready;
    end
  end

  // Arbitration FSM. The grant only moves in IDLE, so a source that drops
  // valid mid-packet keeps the output reserved until its s_last beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE) begin
      if (|s_valid) begin
        grant_d = BITS_REQ'(rr_pick(MAX_REQ'(s_valid), N_REQ, int'(rr_ptr_q)));
        state_d = ST_LOCK;
      end
    end else begin
      if (up_hs && up_last) begin
        rr_ptr_d = grant_q;
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= BITS_REQ'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef OUT_ARB_SKID_EN
  localparam int SKID_W = 1 + USER_W + DATA_W;

  logic [SKID_W-1:0] skid_out;
  logic              skid_last;

  axis_skid_buf #(
    .W (SKID_W)
  ) u_skid (
    .clk     (aclk),
    .rst_n   (aresetn),
    .s_valid (up_valid),
    .s_ready (up_ready),
    .s_data  ({up_last, up_user, up_data}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (skid_out)
  );

  assign {skid_last, m_user, m_data} = skid_out;
  // The stored last bit of a drained entry is stale; qualify it with valid.
  assign m_last = m_valid && skid_last;
`else
  assign up_ready = m_ready;
  assign m_valid  = up_valid;
  assign m_last   = up_valid && up_last;
  assign m_user   = up_user;
  assign m_data   = up_data;
`endif

endmodule

// File: tb/tb_axis_out_arb.sv
// -----------------------------------------------------------------------------
// tb_axis_out_arb
//
// Directed bench for axis_out_arb with N_REQ = 2. Each scenario task builds a
// per-cycle table of hand-computed expectations (valid, grant, s_ready, which
// packet/beat of which source should be on m_*) and compares inline.
// Sources are modelled as packet generators whose beat counters advance on
// their own s_valid && s_ready handshakes.
// -----------------------------------------------------------------------------
module tb_axis_out_arb;
  import axis_out_arb_pkg::*;

  localparam int WW     = WORD_WIDTH_ACC_P;
  localparam int DATA_W = COLS_P * ROWS_P * WW;
  localparam int NW     = COLS_P * ROWS_P;

  typedef struct {
    logic [1:0] en;
    logic       mrdy;
    logic       vld;
    logic [0:0] gnt;
    logic [1:0] srdy;
    int         pkt;
    int         beat;
  } vec_t;

  // ---------------------------------------------------------------- clock/reset
  logic                aclk;
  logic                aresetn;
  logic [1:0]          s_valid;
  logic [1:0]          s_ready;
  logic [1:0]          s_last;
  tuser_st [1:0]       s_user;
  logic [2*DATA_W-1:0] s_data;
  logic                m_ready;
  logic                m_valid;
  logic                m_last;
  tuser_st             m_user;
  logic [DATA_W-1:0]   m_data;
  logic [0:0]          m_grant;
  logic [0:0]          dbg_state;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  axis_out_arb #(
    .N_REQ (2)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .s_user    (s_user),
    .s_data    (s_data),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_user    (m_user),
    .m_data    (m_data),
    .m_grant   (m_grant),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int                n_vec;
  int                n_err;
  int                src_pkt[2];
  int                src_beat[2];
  int                src_len[2];
  logic [DATA_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] make_word(input int src, input int pkt, input int beat);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < NW; k++) begin
      w[k*WW +: WW] = WW'(src * 4096 + pkt * 256 + beat * 16 + k);
    end
    return w;
  endfunction

  function automatic tuser_st make_user(input int src, input int pkt);
    tuser_st u;
    u.tag  = 4'(pkt);
    u.kind = 4'(src);
    return u;
  endfunction

  function automatic vec_t v(input int en, input int mrdy, input int vld, input int gnt,
                             input int srdy, input int pkt, input int beat);
    vec_t r;
    r.en   = 2'(en);
    r.mrdy = 1'(mrdy);
    r.vld  = 1'(vld);
    r.gnt  = 1'(gnt);
    r.srdy = 2'(srdy);
    r.pkt  = pkt;
    r.beat = beat;
    return r;
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_sources(input logic [1:0] en);
    for (int i = 0; i < 2; i++) begin
      s_valid[i]                  = en[i];
      s_data[i*DATA_W +: DATA_W]  = make_word(i, src_pkt[i], src_beat[i]);
      s_user[i]                   = make_user(i, src_pkt[i]);
      s_last[i]                   = en[i] && (src_beat[i] == src_len[i] - 1);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive_cycle(input logic [1:0] en, input logic mrdy);
    @(negedge aclk);
    drive_sources(en);
    m_ready = mrdy;
    #1;
  endtask

  // Called after sampling: sources whose beat was accepted move on.
  task automatic advance_sources();
    for (int i = 0; i < 2; i++) begin
      if (s_valid[i] && s_ready[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_pkt[i]++;
        end else begin
          src_beat[i]++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_user  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_pkt[i]  = 0;
      src_beat[i] = 0;
    end
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = 2'b11;
    s_last  = 2'b11;
    s_user  = '0;
    s_data  = '1;
    m_ready = 1'b1;
    @(negedge aclk);
    #1;
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_m_valid: got %b want 0", m_valid);
    end
    n_vec++;
    if (m_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_m_last: got %b want 0", m_last);
    end
    n_vec++;
    if (s_ready !== 2'b00) begin
      n_err++;
      $display("FAIL reset_s_ready: got %b want 00", s_ready);
    end
    n_vec++;
    if ({m_grant, dbg_state} !== {1'b0, ST_IDLE}) begin
      n_err++;
      $display("FAIL reset_grant_state: got g=%0d st=%0d want g=0 st=0", m_grant, dbg_state);
    end
    do_reset();
  endtask

  // Both sources always requesting 3-beat packets: strict alternation, one
  // idle cycle between packets.
  task automatic test_rotation();
    vec_t tbl[$];
    logic exp_last;
    do_reset();
    src_len[0] = 3;
    src_len[1] = 3;
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 1));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 2));
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 0, 1));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 0, 2));
    tbl.push_back(v(2'b11, 1, 0, 1, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 1, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 1, 1));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 1, 2));
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 1, 0));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 1, 1));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 1, 2));
    tbl.push_back(v(2'b00, 1, 0, 1, 2'b00, 0, 0));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL rotation_ctl c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      if (tbl[c].vld) begin
        n_vec++;
        if ({m_user, m_data} !== {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)}) begin
          n_err++;
          $display("FAIL rotation_data c%0d: got %h want %h", c, {m_user, m_data},
                   {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)});
        end
      end
      advance_sources();
    end
  endtask

  // src0 stalls for 4 cycles mid-packet; src1 must not steal the output.
  task automatic test_valid_drop();
    vec_t tbl[$];
    logic exp_last;
    do_reset();
    src_len[0] = 4;
    src_len[1] = 2;
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 0));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(v(2'b10, 1, 0, 0, 2'b01, 0, 0));
    end
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 1));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 2));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 3));
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 1, 2'b10, 0, 1));
    tbl.push_back(v(2'b00, 1, 0, 1, 2'b00, 0, 0));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL valid_drop_ctl c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      if (tbl[c].vld) begin
        n_vec++;
        if ({m_user, m_data} !== {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)}) begin
          n_err++;
          $display("FAIL valid_drop_data c%0d: got %h want %h", c, {m_user, m_data},
                   {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)});
        end
      end
      advance_sources();
    end
  endtask

  // Only src1, single-beat packets: one handshake every second cycle.
  task automatic test_back_to_back();
    vec_t tbl[$];
    logic exp_last;
    do_reset();
    src_len[0] = 3;
    src_len[1] = 1;
    for (int p = 0; p < 4; p++) begin
      tbl.push_back(v(2'b10, 1, 0, (p == 0) ? 0 : 1, 2'b00, 0, 0));
      tbl.push_back(v(2'b10, 1, 1, 1, 2'b10, p, 0));
    end
    tbl.push_back(v(2'b00, 1, 0, 1, 2'b00, 0, 0));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL back_to_back_ctl c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      if (tbl[c].vld) begin
        n_vec++;
        if ({m_user, m_data} !== {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)}) begin
          n_err++;
          $display("FAIL back_to_back_data c%0d: got %h want %h", c, {m_user, m_data},
                   {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)});
        end
      end
      advance_sources();
    end
  endtask

  // m_ready toggles during a 4-beat src0 packet; every accepted beat is
  // checked against an ordered expected queue.
  task automatic test_mready_toggle();
    vec_t tbl[$];
    logic exp_last;
    int   hs_cnt;
    do_reset();
    src_len[0] = 4;
    src_len[1] = 2;
    hs_cnt     = 0;
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(make_word(0, 0, b));
    end
    tbl.push_back(v(2'b01, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b01, 0, 1, 0, 2'b00, 0, 1));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 0, 1));
    tbl.push_back(v(2'b01, 0, 1, 0, 2'b00, 0, 2));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 0, 2));
    tbl.push_back(v(2'b01, 0, 1, 0, 2'b00, 0, 3));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 0, 3));
    tbl.push_back(v(2'b00, 1, 0, 0, 2'b00, 0, 0));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL mready_ctl c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL mready_extra_beat c%0d: got %h want none", c, m_data);
        end else if (m_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL mready_order c%0d: got %h want %h", c, m_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      advance_sources();
    end
    n_vec++;
    if (hs_cnt != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mready_count: got %0d handshakes, %0d left want 4, 0", hs_cnt, exp_q.size());
    end
  endtask

  // Reset lands after two accepted beats of a 5-beat src0 packet.
  task automatic test_reset_midpacket();
    vec_t tbl[$];
    logic exp_last;
    do_reset();
    src_len[0] = 5;
    src_len[1] = 2;
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 1));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL midrst_pre c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      advance_sources();
    end
    @(negedge aclk);
    drive_sources(2'b11);
    aresetn = 1'b0;
    #1;
    n_vec++;
    if ({m_valid, s_ready, m_grant, dbg_state} !== {1'b0, 2'b00, 1'b0, ST_IDLE}) begin
      n_err++;
      $display("FAIL midrst_in_reset: got v=%b rdy=%b g=%0d st=%0d want v=0 rdy=00 g=0 st=0",
               m_valid, s_ready, m_grant, dbg_state);
    end
    do_reset();
    tbl.delete();
    tbl.push_back(v(2'b11, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b11, 1, 1, 0, 2'b01, 0, 1));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL midrst_post c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      if (tbl[c].vld) begin
        n_vec++;
        if (m_data !== make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)) begin
          n_err++;
          $display("FAIL midrst_post_data c%0d: got %h want %h", c, m_data,
                   make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat));
        end
      end
      advance_sources();
    end
  endtask

`ifdef OUT_ARB_SKID_EN
  // Skid build: beats appear one cycle after their upstream handshake, a
  // one-cycle m_ready drop is absorbed without loss.
  task automatic test_skid();
    vec_t tbl[$];
    logic exp_last;
    do_reset();
    src_len[0] = 3;
    src_len[1] = 2;
    tbl.push_back(v(2'b01, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(2'b01, 1, 0, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 0, 1));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b00, 0, 2));
    tbl.push_back(v(2'b01, 1, 0, 0, 2'b01, 0, 0));
    tbl.push_back(v(2'b01, 0, 1, 0, 2'b01, 1, 0));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b00, 1, 0));
    tbl.push_back(v(2'b01, 1, 1, 0, 2'b01, 1, 1));
    tbl.push_back(v(2'b00, 1, 1, 0, 2'b00, 1, 2));
    tbl.push_back(v(2'b00, 1, 0, 0, 2'b00, 0, 0));
    for (int c = 0; c < tbl.size(); c++) begin
      drive_cycle(tbl[c].en, tbl[c].mrdy);
      exp_last = tbl[c].vld && (tbl[c].beat == src_len[tbl[c].gnt] - 1);
      n_vec++;
      if ({m_valid, m_grant, s_ready, m_last} !== {tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last}) begin
        n_err++;
        $display("FAIL skid_ctl c%0d: got v=%b g=%0d rdy=%b last=%b want v=%b g=%0d rdy=%b last=%b",
                 c, m_valid, m_grant, s_ready, m_last, tbl[c].vld, tbl[c].gnt, tbl[c].srdy, exp_last);
      end
      if (tbl[c].vld) begin
        n_vec++;
        if ({m_user, m_data} !== {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)}) begin
          n_err++;
          $display("FAIL skid_data c%0d: got %h want %h", c, {m_user, m_data},
                   {make_user(tbl[c].gnt, tbl[c].pkt), make_word(tbl[c].gnt, tbl[c].pkt, tbl[c].beat)});
        end
      end
      advance_sources();
    end
  endtask
`endif

  // ---------------------------------------------------------------- sequence
  initial begin
    n_vec   = 0;
    n_err   = 0;
    aresetn = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_user  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_pkt[i]  = 0;
      src_beat[i] = 0;
      src_len[i]  = 1;
    end
    test_reset();
`ifdef OUT_ARB_SKID_EN
    test_skid();
`else
    test_rotation();
    test_valid_drop();
    test_back_to_back();
    test_mready_toggle();
    test_reset_midpacket();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
